// File: rtl/pll_lock_supervisor_if.sv
// PLL status/control bundle between the lock supervisor (master) and the PLL/downstream side
// (slave).
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output relock_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  relock_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: qualifies lock, releases sys_rst, re-initialises the PLL on loss.
// Define PLL_SUP_RETRY_EN to retry after a lock timeout instead of parking in FAULT.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned MaxAB    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCount = (MaxAB > LOCK_STABLE_CYCLES) ? MaxAB : LOCK_STABLE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxCount) + 1;

  localparam logic [CntW-1:0] LastRst    = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] LastTo     = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] LastStable = CntW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StPllReset,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   relock_inc;
  logic                   pll_rst_d;
  logic                   pll_rst_q, sys_rst_q, ready_q, fault_q;
  logic [7:0]             relock_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    relock_inc = 1'b0;
    unique case (state_q)
      StPllReset: if (cnt_q == LastRst) state_d = StWaitLock;
      // Lock takes priority over a coincident timeout.
      StWaitLock: begin
        if (lock_s)                 state_d = StStable;
        else if (cnt_q == LastTo)   state_d = StFault;
      end
      StStable: begin
        if (!lock_s)                  state_d = StWaitLock;
        else if (cnt_q == LastStable) state_d = StRun;
      end
      StRun: begin
        if (!lock_s) begin
          state_d    = StPllReset;
          relock_inc = 1'b1;
        end
      end
      StFault: begin
`ifdef PLL_SUP_RETRY_EN
        state_d    = StPllReset;
        relock_inc = 1'b1;
`else
        state_d    = StFault;
`endif
      end
      default: state_d = StPllReset;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

`ifdef PLL_SUP_RETRY_EN
    // The single FAULT cycle keeps pll_rst low so each retry pulse is exactly PLL_RST_CYCLES.
    pll_rst_d = (state_d == StPllReset);
`else
    pll_rst_d = (state_d == StPllReset) || (state_d == StFault);
`endif
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StPllReset;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      relock_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
      fault_q   <= fault_q | (state_d == StFault);
      if (relock_inc && (relock_q != 8'hff)) begin
        relock_q <= relock_q + 8'd1;
      end
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a scoreboard of expected output snapshots.
module tb_pll_lock_supervisor;

  localparam int unsigned SyncStages  = 2;
  localparam int unsigned PllRst      = 4;
  localparam int unsigned LockTimeout = 64;
  localparam int unsigned LockStable  = 16;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES        (SyncStages),
    .PLL_RST_CYCLES     (PllRst),
    .LOCK_TIMEOUT_CYCLES(LockTimeout),
    .LOCK_STABLE_CYCLES (LockStable)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus.master)
  );

  always #10 refclk = ~refclk;

  // Snapshot layout: {pll_rst, sys_rst, ready, fault, relock_count[7:0]}
  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [11:0] outs();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.relock_count};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic pr, input logic sr, input logic rd,
                          input logic ft, input logic [7:0] rc);
    exp_t e;
    e.tag = tag;
    e.val = {pr, sr, rd, ft, rc};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, 32'(outs()), 32'(e.val));
    end
  endtask

  // One active edge, then sample just after it.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    rst            = 1'b1;

    // Power-up under reset
    repeat (3) @(posedge refclk);
    #1;
    push_exp("reset_values", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    pop_check();

    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("pll_rst_high", 32'(bus.pll_rst), 32'd1);
    end
    tick();
    chk("pll_rst_falls_edge4", 32'(bus.pll_rst), 32'd0);
    for (int i = 5; i <= 9; i++) begin
      tick();
      chk("sys_rst_held", 32'({bus.sys_rst, bus.ready}), 32'b10);
    end

    // Clean lock: first high sample at edge 10
    bus.pll_locked = 1'b1;
    push_exp("clean_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (SyncStages + LockStable) tick();
    chk("clean_no_early_release", 32'(bus.ready), 32'd0);
    tick();
    pop_check();

    // Lock loss in RUN for 50 refclk cycles (1 us)
    bus.pll_locked = 1'b0;
    push_exp("loss_reinit", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    repeat (SyncStages) tick();
    chk("loss_not_early", 32'(bus.ready), 32'd1);
    tick();
    pop_check();
    repeat (47) tick();
    bus.pll_locked = 1'b1;
    push_exp("re_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    repeat (SyncStages + LockStable) tick();
    chk("re_no_early_release", 32'(bus.ready), 32'd0);
    tick();
    pop_check();

    // Second loss, then reset asserted while in STABLE
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    chk("relock_count_2", 32'(bus.relock_count), 32'd2);
    repeat (10) tick();
    bus.pll_locked = 1'b1;
    repeat (5) tick();
    chk("in_stable_pll_rst_low", 32'(bus.pll_rst), 32'd0);
    #4;
    rst = 1'b1;
    #1;
    push_exp("async_reset_mid_stable", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    pop_check();

    // Unstable lock: 8 high samples, 6 low, then high for good
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (9) tick();
    bus.pll_locked = 1'b1;
    repeat (8) tick();
    bus.pll_locked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("unstable_no_release", 32'(bus.ready), 32'd0);
    end
    bus.pll_locked = 1'b1;
    push_exp("unstable_final_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < int'(SyncStages + LockStable); i++) begin
      tick();
      chk("unstable_wait", 32'(bus.ready), 32'd0);
    end
    tick();
    pop_check();

    // Timeout with lock never arriving
    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat (PllRst + LockTimeout - 1) tick();
    chk("no_early_fault", 32'(bus.fault), 32'd0);
`ifdef PLL_SUP_RETRY_EN
    push_exp("timeout_fault", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    tick();
    pop_check();
    push_exp("retry_pulse", 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    tick();
    pop_check();
    repeat ((1 + PllRst + LockTimeout) * 300) tick();
    chk("relock_saturates", 32'(bus.relock_count), 32'd255);
`else
    push_exp("timeout_fault", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    tick();
    pop_check();
    repeat (40) tick();
    push_exp("fault_terminal", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    pop_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
